adc_gate_sequencer: RTL and testbench

ADC_GATE_SEQUENCER -- requirements
Module: adc_gate_sequencer

---
 rtl/adc_gate_sequencer_if.sv | 18 +
 rtl/adc_gate_sequencer.sv | 178 +++++++++++++++++
 tb/tb_adc_gate_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/adc_gate_sequencer_if.sv
// adc_gate_sequencer_if
//   AXI4-Stream bundle used for the raw ADC input and the gated output.
//   tdata  : sample word (8 samples x 16 bits at the default width)
//   tvalid : source qualifier
//   tready : sink acceptance
//   Modports:
//     master : drives tdata/tvalid, observes tready
//     slave  : observes tdata/tvalid, drives tready
interface adc_gate_sequencer_if #(
    parameter int DATA_WIDTH = 128
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/adc_gate_sequencer.sv
// adc_gate_sequencer
//   Capture-triggered gate sequencer for a free-running ADC stream.
//   A rising edge on capture_i (accepted only in IDLE) walks the FSM through
//   PRE -> GATE -> POST -> RST. The stream is passed through while GATE is
//   active and zeroed otherwise; RST drives a reset to the downstream biquads.
//
//   Ports:
//     aclk, aresetn        clock, asynchronous active-low reset
//     capture_i            capture request (level, edge-detected)
//     pre_dly_i            cycles from capture edge to gate open
//     gate_len_i           cycles the gate is open
//     post_dly_i           cycles from gate close to filter reset
//     rst_len_i            cycles the filter reset is held
//     s_axis (slave)       raw ADC stream
//     m_axis (master)      gated stream, 1-cycle latency
//     gate_o               gate open indicator
//     bq_rst_o             synchronous reset to downstream biquad8 wrappers
//     busy_o               sequence in progress
//     state_dbg_o          current FSM state (IDLE=0 PRE=1 GATE=2 POST=3 RST=4)
//
//   Stream handshake: the ADC domain is free running and cannot stall, so
//   out of reset m_axis.tvalid and s_axis.tready are held at 1 and the
//   opposite side's s_axis.tvalid / m_axis.tready are not consulted; every
//   cycle carries exactly one word in each direction.
module adc_gate_sequencer #(
    parameter int DATA_WIDTH = 128,
    parameter int CNT_BITS   = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  capture_i,
    input  logic [CNT_BITS-1:0]   pre_dly_i,
    input  logic [CNT_BITS-1:0]   gate_len_i,
    input  logic [CNT_BITS-1:0]   post_dly_i,
    input  logic [CNT_BITS-1:0]   rst_len_i,
    adc_gate_sequencer_if.slave   s_axis,
    adc_gate_sequencer_if.master  m_axis,
    output logic                  gate_o,
    output logic                  bq_rst_o,
    output logic                  busy_o,
    output logic [2:0]            state_dbg_o
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_GATE = 3'd2,
        ST_POST = 3'd3,
        ST_RST  = 3'd4
    } state_t;

    typedef struct packed {
        state_t              st;
        logic [CNT_BITS-1:0] cnt;
    } step_t;

    state_t                state_q, state_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic [CNT_BITS-1:0]   pre_q, pre_d;
    logic [CNT_BITS-1:0]   gate_q, gate_d;
    logic [CNT_BITS-1:0]   post_q, post_d;
    logic [CNT_BITS-1:0]   rlen_q, rlen_d;
    logic                  cap_q;
    logic                  armed_q;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  accept;
    step_t                 nxt;

    // Returns the first state at or after 'from' whose length is non-zero,
    // with its counter preloaded to length-1. Zero-length states are skipped
    // in zero cycles; if nothing remains the sequence ends in IDLE.
    // 'from' is a raw 3-bit code so RST+1 can mean "past the last state".
    function automatic step_t pick(
        input logic [2:0]          from,
        input logic [CNT_BITS-1:0] p,
        input logic [CNT_BITS-1:0] g,
        input logic [CNT_BITS-1:0] o,
        input logic [CNT_BITS-1:0] r
    );
        step_t s;
        s.st  = ST_IDLE;
        s.cnt = '0;
        if (from <= 3'(ST_PRE) && p != '0) begin
            s.st  = ST_PRE;
            s.cnt = p - 1'b1;
        end else if (from <= 3'(ST_GATE) && g != '0) begin
            s.st  = ST_GATE;
            s.cnt = g - 1'b1;
        end else if (from <= 3'(ST_POST) && o != '0) begin
            s.st  = ST_POST;
            s.cnt = o - 1'b1;
        end else if (from <= 3'(ST_RST) && r != '0) begin
            s.st  = ST_RST;
            s.cnt = r - 1'b1;
        end
        return s;
    endfunction

    // armed_q blocks a capture that is already high when reset releases:
    // a 0 sample must be seen before any edge counts.
    assign accept = capture_i & ~cap_q & armed_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        gate_d  = gate_q;
        post_d  = post_q;
        rlen_d  = rlen_q;
        nxt     = '{st: ST_IDLE, cnt: '0};

        if (state_q == ST_IDLE) begin
            if (accept) begin
                pre_d   = pre_dly_i;
                gate_d  = gate_len_i;
                post_d  = post_dly_i;
                rlen_d  = rst_len_i;
                nxt     = pick(3'(ST_PRE), pre_dly_i, gate_len_i, post_dly_i, rst_len_i);
                state_d = nxt.st;
                cnt_d   = nxt.cnt;
            end
        end else if (cnt_q == '0) begin
            nxt     = pick(3'(state_q) + 3'd1, pre_q, gate_q, post_q, rlen_q);
            state_d = nxt.st;
            cnt_d   = nxt.cnt;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Output word is captured alongside the gate state of the same cycle,
    // so m_axis.tdata lags gate_o by exactly one cycle.
    always_comb begin
        tdata_d = '0;
        if (state_q == ST_GATE) begin
            tdata_d = s_axis.tdata;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pre_q   <= '0;
            gate_q  <= '0;
            post_q  <= '0;
            rlen_q  <= '0;
            cap_q   <= 1'b0;
            armed_q <= 1'b0;
            valid_q <= 1'b0;
            tdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            gate_q  <= gate_d;
            post_q  <= post_d;
            rlen_q  <= rlen_d;
            cap_q   <= capture_i;
            armed_q <= armed_q | ~capture_i;
            valid_q <= 1'b1;
            tdata_q <= tdata_d;
        end
    end

    assign gate_o        = (state_q == ST_GATE);
    assign bq_rst_o      = (state_q == ST_RST);
    assign busy_o        = (state_q != ST_IDLE);
    assign state_dbg_o   = state_q;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = valid_q;
    assign s_axis.tready = valid_q;

    logic unused_handshake;
    assign unused_handshake = s_axis.tvalid ^ m_axis.tready;

endmodule

// File: tb/tb_adc_gate_sequencer.sv
// tb_adc_gate_sequencer
//   Bench for adc_gate_sequencer. Expected gate/bq_rst/busy come from the
//   absolute cycle windows of each accepted capture; expected output words
//   are queued when the input word is driven and popped a cycle later.
module tb_adc_gate_sequencer;

  localparam int DW = 128;
  localparam int CB = 16;

  logic          clk;
  logic          aresetn;
  logic          capture_i;
  logic [CB-1:0] pre_dly_i;
  logic [CB-1:0] gate_len_i;
  logic [CB-1:0] post_dly_i;
  logic [CB-1:0] rst_len_i;
  logic          gate_o;
  logic          bq_rst_o;
  logic          busy_o;
  logic [2:0]    state_dbg_o;

  adc_gate_sequencer_if #(.DATA_WIDTH(DW)) s_axis_if ();
  adc_gate_sequencer_if #(.DATA_WIDTH(DW)) m_axis_if ();

  adc_gate_sequencer #(.DATA_WIDTH(DW), .CNT_BITS(CB)) dut (
    .aclk        (clk),
    .aresetn     (aresetn),
    .capture_i   (capture_i),
    .pre_dly_i   (pre_dly_i),
    .gate_len_i  (gate_len_i),
    .post_dly_i  (post_dly_i),
    .rst_len_i   (rst_len_i),
    .s_axis      (s_axis_if),
    .m_axis      (m_axis_if),
    .gate_o      (gate_o),
    .bq_rst_o    (bq_rst_o),
    .busy_o      (busy_o),
    .state_dbg_o (state_dbg_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters / scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", tag, obs, exp, $time);
    end
  endtask

  // reference state: windows of the most recent accepted capture
  longint cyc      = 0;
  longint e_cyc    = 0;
  bit     seq_on   = 0;
  longint l_pre, l_gate, l_post, l_rst;
  bit     prev_cap = 0;
  bit     armed    = 0;
  bit     live     = 0;

  always @(negedge clk) begin
    logic          g_e, b_e, y_e;
    logic [DW-1:0] td_e;
    longint        g_lo, g_hi, r_lo, r_hi, y_hi;
    cyc++;
    if (!aresetn) begin
      check("rst_gate", DW'(gate_o), '0);
      check("rst_bq_rst", DW'(bq_rst_o), '0);
      check("rst_busy", DW'(busy_o), '0);
      check("rst_tdata", m_axis_if.tdata, '0);
      check("rst_tvalid", DW'(m_axis_if.tvalid), '0);
      seq_on   = 0;
      prev_cap = 0;
      armed    = 0;
      live     = 0;
      exp_q.delete();
    end else begin
      g_lo = e_cyc + 1 + l_pre;
      g_hi = e_cyc + l_pre + l_gate;
      r_lo = g_hi + l_post + 1;
      r_hi = g_hi + l_post + l_rst;
      y_hi = r_hi;
      g_e = seq_on && cyc >= g_lo && cyc <= g_hi;
      b_e = seq_on && cyc >= r_lo && cyc <= r_hi;
      y_e = seq_on && cyc >= e_cyc + 1 && cyc <= y_hi;
      check("gate_o", DW'(gate_o), DW'(g_e));
      check("bq_rst_o", DW'(bq_rst_o), DW'(b_e));
      check("busy_o", DW'(busy_o), DW'(y_e));
      td_e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      check("m_tdata", m_axis_if.tdata, td_e);
      check("m_tvalid", DW'(m_axis_if.tvalid), DW'(live));
      check("s_tready", DW'(s_axis_if.tready), DW'(live));
      exp_q.push_back(g_e ? s_axis_if.tdata : '0);
      if (capture_i && !prev_cap && armed && !y_e) begin
        e_cyc  = cyc;
        seq_on = 1;
        l_pre  = longint'(pre_dly_i);
        l_gate = longint'(gate_len_i);
        l_post = longint'(post_dly_i);
        l_rst  = longint'(rst_len_i);
      end
      armed    = armed | !capture_i;
      prev_cap = capture_i;
      live     = 1;
    end
  end

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int p, input int g, input int o, input int r);
    pre_dly_i  = CB'(p);
    gate_len_i = CB'(g);
    post_dly_i = CB'(o);
    rst_len_i  = CB'(r);
  endtask

  task automatic pulse(input int p, input int g, input int o, input int r);
    set_len(p, g, o, r);
    capture_i = 1'b1;
    tick(1);
    capture_i = 1'b0;
  endtask

  // free-running ADC data and ignored handshake inputs
  initial begin
    s_axis_if.tdata  = '0;
    s_axis_if.tvalid = 1'b0;
    m_axis_if.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      s_axis_if.tdata  = {$urandom, $urandom, $urandom, $urandom};
      s_axis_if.tvalid = 1'($urandom_range(0, 1));
      m_axis_if.tready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    aresetn   = 1'b0;
    capture_i = 1'b0;
    set_len(0, 0, 0, 0);
    tick(4);
    aresetn = 1'b1;
    tick(3);

    // nominal sequence 3/5/2/4
    pulse(3, 5, 2, 4);
    tick(20);

    // all lengths zero
    pulse(0, 0, 0, 0);
    tick(5);

    // long gate; inputs change at E+10, second edge at E+20
    pulse(1, 100, 1, 1);
    tick(9);
    set_len(7, 1, 7, 7);
    tick(10);
    capture_i = 1'b1;
    tick(1);
    capture_i = 1'b0;
    tick(100);

    // back-to-back, then an edge on the last busy cycle (ignored)
    pulse(3, 5, 2, 4);
    tick(14);
    pulse(3, 5, 2, 4);
    tick(13);
    capture_i = 1'b1;
    tick(2);
    capture_i = 1'b0;
    tick(20);

    // reset mid-GATE with capture held high across release
    pulse(2, 50, 2, 2);
    tick(9);
    capture_i = 1'b1;
    aresetn   = 1'b0;
    tick(3);
    aresetn = 1'b1;
    tick(10);
    capture_i = 1'b0;
    tick(2);
    pulse(2, 5, 1, 3);
    tick(20);

    // random captures and lengths
    for (int i = 0; i < 300; i++) begin
      capture_i = ($urandom_range(0, 3) == 0);
      set_len($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6));
      tick(1);
    end
    capture_i = 1'b0;
    tick(40);

    // maximum gate length
    pulse(0, 65535, 0, 1);
    tick(65540);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
